// File: rtl/icache_fetch_pkg.sv
// rtl/icache_fetch_pkg.sv - shared constants, FSM state type and address-field helpers for the fetch front end
package icache_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INDEX_W_DEFAULT  = 6;
  localparam int          OFFSET_W_DEFAULT = 2;
  localparam int          BYTE_W           = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_e;

  function automatic int tag_width(input int index_w, input int offset_w);
    return 32 - index_w - offset_w - BYTE_W;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - direct-mapped tag/valid/data arrays with async read, word write and tag commit
module icache_line_store
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_W  = INDEX_W_DEFAULT,
  parameter int OFFSET_W = OFFSET_W_DEFAULT,
  parameter int TAG_W    = tag_width(INDEX_W_DEFAULT, OFFSET_W_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [31:0]         rd_data_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [31:0]         wr_data_i,
  input  logic                commit_en_i,
  input  logic [INDEX_W-1:0]  commit_index_i,
  input  logic [TAG_W-1:0]    commit_tag_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  // Only the valid bits are reset; tags and data are meaningless until committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (commit_en_i) begin
      valid_q[commit_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
    if (commit_en_i) begin
      tag_q[commit_index_i] <= commit_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - IF1/IF2 fetch front end with direct-mapped icache and line-refill FSM
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int          INDEX_W  = INDEX_W_DEFAULT,
  parameter int          OFFSET_W = OFFSET_W_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_if1_if2,
  input  logic        flush_if1_if2,
  input  logic        npc_sel_ex,
  input  logic [31:0] npc_ex,
  output logic [31:0] pc_if2,
  output logic [31:0] inst_if2,
  output logic        valid_if2,
  output logic        inst_sram_miss,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int          TAG_W     = tag_width(INDEX_W, OFFSET_W);
  localparam int          LINE_LSB  = OFFSET_W + BYTE_W;
  localparam logic [31:0] LINE_MASK = 32'((64'd1 << LINE_LSB) - 64'd1);

  logic [31:0]         pc_q, pc_d;
  logic [31:0]         pc_if2_q, pc_if2_d;
  logic                valid_if2_q, valid_if2_d;
  fill_state_e         state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [31:0]         base_q, base_d;

  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [31:0]         line_word;
  logic                hit;
  logic                wr_en;
  logic                commit_en;

  icache_line_store #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_line_store (
    .clk            (clk),
    .rst            (rst),
    .rd_index_i     (pc_if2_q[LINE_LSB +: INDEX_W]),
    .rd_offset_i    (pc_if2_q[BYTE_W +: OFFSET_W]),
    .rd_valid_o     (line_valid),
    .rd_tag_o       (line_tag),
    .rd_data_o      (line_word),
    .wr_en_i        (wr_en),
    .wr_index_i     (base_q[LINE_LSB +: INDEX_W]),
    .wr_offset_i    (beat_q),
    .wr_data_i      (mem_rdata),
    .commit_en_i    (commit_en),
    .commit_index_i (base_q[LINE_LSB +: INDEX_W]),
    .commit_tag_i   (base_q[31 -: TAG_W])
  );

  assign hit            = valid_if2_q && line_valid && (line_tag == pc_if2_q[31 -: TAG_W]);
  assign inst_sram_miss = (valid_if2_q && !hit) || (state_q != IDLE);

  // Redirect always wins, even while the refill is stalling the front end.
  always_comb begin
    pc_d = pc_q;
    if (npc_sel_ex) begin
      pc_d = npc_ex;
    end else if (!(stall_pc || inst_sram_miss)) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    pc_if2_d    = pc_if2_q;
    valid_if2_d = valid_if2_q;
    if (flush_if1_if2) begin
      valid_if2_d = 1'b0;
    end else if (!stall_if1_if2) begin
      pc_if2_d    = pc_q;
      valid_if2_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pc_if2_q    <= '0;
      valid_if2_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_if2_q    <= pc_if2_d;
      valid_if2_q <= valid_if2_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  // A started burst always runs to COMMIT; flushes and redirects never abort it.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (valid_if2_q && !hit) begin
          base_d  = pc_if2_q & ~LINE_MASK;
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    wr_en     = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = base_q | 32'({beat_q, 2'b00});
        wr_en    = mem_ack;
      end
      COMMIT: begin
        commit_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_if2    = pc_if2_q;
  assign valid_if2 = valid_if2_q;
  assign inst_if2  = (valid_if2_q && !inst_sram_miss) ? line_word : NOP_INST;

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - directed self-checking bench for icache_fetch
module tb_icache_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PAT = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_stall_pc, tb_stall_if;
  logic        stall_pc, stall_if1_if2, flush_if1_if2;
  logic        npc_sel_ex;
  logic [31:0] npc_ex;
  logic [31:0] pc_if2, inst_if2;
  logic        valid_if2, inst_sram_miss;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int ack_delay;
  int wait_cnt;
  int n, unstable;
  logic [31:0] first_addr;

  always #5 clk = ~clk;

  // Hazard unit stand-in: a miss stalls PC and IF1/IF2, a redirect flushes IF2.
  assign stall_pc      = tb_stall_pc | inst_sram_miss;
  assign stall_if1_if2 = tb_stall_if | inst_sram_miss;
  assign flush_if1_if2 = npc_sel_ex;

  // Memory: each beat is acked after ack_delay waiting cycles; data is address ^ PAT.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_addr ^ PAT;

  icache_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pc       (stall_pc),
    .stall_if1_if2  (stall_if1_if2),
    .flush_if1_if2  (flush_if1_if2),
    .npc_sel_ex     (npc_sel_ex),
    .npc_ex         (npc_ex),
    .pc_if2         (pc_if2),
    .inst_if2       (inst_if2),
    .valid_if2      (valid_if2),
    .inst_sram_miss (inst_sram_miss),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    npc_sel_ex = 1'b1;
    npc_ex     = target;
    @(negedge clk);
    npc_sel_ex = 1'b0;
    @(negedge clk);
  endtask

  // Counts consecutive miss cycles from the current one; flags mem_addr/mem_req moving before an ack.
  task automatic run_miss(output int cnt, output logic [31:0] first, output int bad);
    logic        prev_req, prev_ack, seen;
    logic [31:0] prev_addr;
    cnt = 0; bad = 0; first = 32'hFFFF_FFFF; seen = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    while (inst_sram_miss && cnt < 200) begin
      if (mem_req && !seen) begin
        first = mem_addr;
        seen  = 1'b1;
      end
      if (prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr)) bad++;
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; tb_stall_pc = 1'b0; tb_stall_if = 1'b0;
    npc_sel_ex = 1'b0; npc_ex = '0; ack_delay = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc_if2", pc_if2, 32'h0);
    chk("rst_valid", 32'(valid_if2), 32'h0);
    chk("rst_inst", inst_if2, NOP);
    chk("rst_miss", 32'(inst_sram_miss), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // Cold fetch from 0x0
    @(negedge clk);
    chk("cold_valid", 32'(valid_if2), 32'h1);
    chk("cold_miss1", 32'(inst_sram_miss), 32'h1);
    chk("cold_req_idle", 32'(mem_req), 32'h0);
    chk("cold_inst_nop", inst_if2, NOP);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("cold_req", 32'(mem_req), 32'h1);
      chk("cold_addr", mem_addr, 32'(b * 4));
      chk("cold_miss_fill", 32'(inst_sram_miss), 32'h1);
    end
    @(negedge clk);
    chk("cold_commit_req", 32'(mem_req), 32'h0);
    chk("cold_commit_miss", 32'(inst_sram_miss), 32'h1);
    @(negedge clk);
    chk("hit0_miss", 32'(inst_sram_miss), 32'h0);
    chk("hit0_pc", pc_if2, 32'h0);
    chk("hit0_inst", inst_if2, 32'hDEAD_0000);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("seq_pc", pc_if2, 32'(k * 4));
      chk("seq_inst", inst_if2, PAT ^ 32'(k * 4));
      chk("seq_miss", 32'(inst_sram_miss), 32'h0);
    end

    // Stall IF1/IF2 and PC for 3 cycles, then PC alone released for one
    tb_stall_pc = 1'b1; tb_stall_if = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_pc_if2", pc_if2, 32'hC);
      chk("stall_inst", inst_if2, 32'hDEAD_000C);
    end
    tb_stall_pc = 1'b0;
    @(negedge clk);
    chk("stall_if_only", pc_if2, 32'hC);
    tb_stall_if = 1'b0;
    @(negedge clk);
    chk("post_stall_pc", pc_if2, 32'h14);
    chk("post_stall_miss", 32'(inst_sram_miss), 32'h1);
    run_miss(n, first_addr, unstable);
    chk("l1_miss_cycles", 32'(n), 32'd6);
    chk("l1_base", first_addr, 32'h10);
    chk("l1_inst", inst_if2, 32'hDEAD_0014);

    // Redirect during beat 2 of the fill at 0x0
    do_reset();
    repeat (4) @(negedge clk);
    chk("rd_beat2_addr", mem_addr, 32'h8);
    npc_sel_ex = 1'b1; npc_ex = 32'h100;
    @(negedge clk);
    npc_sel_ex = 1'b0;
    chk("rd_beat3_addr", mem_addr, 32'hC);
    chk("rd_beat3_req", 32'(mem_req), 32'h1);
    chk("rd_flushed", 32'(valid_if2), 32'h0);
    @(negedge clk);
    chk("rd_commit_miss", 32'(inst_sram_miss), 32'h1);
    chk("rd_commit_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    chk("rd_idle_miss", 32'(inst_sram_miss), 32'h0);
    chk("rd_idle_inst", inst_if2, NOP);
    @(negedge clk);
    chk("rd_new_pc", pc_if2, 32'h100);
    run_miss(n, first_addr, unstable);
    chk("rd_miss_cycles", 32'(n), 32'd6);
    chk("rd_base", first_addr, 32'h100);
    chk("rd_inst", inst_if2, 32'hDEAD_0100);
    redirect(32'h0);
    chk("rd_line0_miss", 32'(inst_sram_miss), 32'h0);
    chk("rd_line0_inst", inst_if2, 32'hDEAD_0000);

    // Conflict: 0x400 shares index 0 with 0x0
    redirect(32'h400);
    chk("cf_pc", pc_if2, 32'h400);
    run_miss(n, first_addr, unstable);
    chk("cf_miss_cycles", 32'(n), 32'd6);
    chk("cf_base", first_addr, 32'h400);
    chk("cf_inst", inst_if2, 32'hDEAD_0400);
    redirect(32'h0);
    chk("cf_evicted_miss", 32'(inst_sram_miss), 32'h1);
    run_miss(n, first_addr, unstable);
    chk("cf_refill_cycles", 32'(n), 32'd6);
    chk("cf_refill_inst", inst_if2, 32'hDEAD_0000);

    // Slow memory: 3 wait cycles per beat
    ack_delay = 3;
    redirect(32'h200);
    run_miss(n, first_addr, unstable);
    chk("slow_miss_cycles", 32'(n), 32'd18);
    chk("slow_base", first_addr, 32'h200);
    chk("slow_unstable", 32'(unstable), 32'd0);
    chk("slow_inst", inst_if2, 32'hDEAD_0200);

    // Reset in the middle of a refill
    redirect(32'h300);
    @(negedge clk);
    chk("mr_fill_req", 32'(mem_req), 32'h1);
    chk("mr_fill_addr", mem_addr, 32'h300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_pc_if2", pc_if2, 32'h0);
    chk("mr_valid", 32'(valid_if2), 32'h0);
    chk("mr_inst", inst_if2, NOP);
    chk("mr_miss", 32'(inst_sram_miss), 32'h0);
    chk("mr_req", 32'(mem_req), 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; ack_delay = 0;
    @(negedge clk);
    chk("mr_first_miss", 32'(inst_sram_miss), 32'h1);
    run_miss(n, first_addr, unstable);
    chk("mr_miss_cycles", 32'(n), 32'd6);
    chk("mr_inst", inst_if2, 32'hDEAD_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
